// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared skid-queue sizing and the read-issue room check
package fifo_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int SKID_DEPTH         = 4;
  localparam int SKID_PTR_W         = 2;
  localparam int SKID_OCC_W         = 3;

  // A read may only be issued while queued words plus the word in flight leave a free slot.
  function automatic logic skid_has_room(input logic [SKID_OCC_W-1:0] occ, input logic inflight);
    logic [SKID_OCC_W:0] committed;
    committed = {1'b0, occ} + {{SKID_OCC_W{1'b0}}, inflight};
    return committed < (SKID_OCC_W+1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port plus outgoing valid/ready stream
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_reader_skid_queue.sv
// rtl/fifo_stream_reader_skid_queue.sv - 4-entry register-file queue absorbing the FIFO read latency
module fifo_stream_reader_skid_queue
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [SKID_OCC_W-1:0] occ,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] hd_ptr;
  logic [SKID_PTR_W-1:0] tl_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tl_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        tl_ptr <= tl_ptr + SKID_PTR_W'(1);
      end
      if (pop) begin
        hd_ptr <= hd_ptr + SKID_PTR_W'(1);
      end
      if (push && !pop) begin
        occ <= occ + SKID_OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - SKID_OCC_W'(1);
      end
    end
  end

  // Stale entries stay hidden so the stream reads zero when nothing is queued.
  assign head_valid = (occ != '0);
  assign head_data  = head_valid ? mem[hd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO pop engine feeding a valid/ready stream; DRAIN_STATS_EN adds flit_count
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef DRAIN_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus
`ifdef DRAIN_STATS_EN
  , output logic [CNT_WIDTH-1:0] flit_count
`endif
);
  logic                  inflight;
  logic                  pop;
  logic [SKID_OCC_W-1:0] occ;

  // Issue depends only on registered state and the FIFO flag, never on out_ready.
  assign bus.fifo_rd_en = ~rst & enable & ~bus.fifo_empty & skid_has_room(occ, inflight);
  assign pop            = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
    end
  end

  fifo_stream_reader_skid_queue #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_data  (bus.fifo_dout),
    .pop        (pop),
    .occ        (occ),
    .head_valid (bus.out_valid),
    .head_data  (bus.out_data)
  );

`ifdef DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_count <= '0;
    end else if (pop) begin
      flit_count <= flit_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
